// File: rtl/add_round_key_stream.sv
// AES AddRoundKey stage: XORs a streamed state with a stored round key, 1-cycle latency.
// Define ARK_SKID_EN to add a one-entry skid buffer so in_ready_o is registered.
module add_round_key_stream #(
    parameter int WIDTH  = 128,
    parameter int ROUNDS = 10,
    localparam int IDXW  = (ROUNDS + 1 > 1) ? $clog2(ROUNDS + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_wr_en_i,
    input  logic [IDXW-1:0]  key_wr_idx_i,
    input  logic [WIDTH-1:0] key_wr_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_state_i,
    input  logic [IDXW-1:0]  in_round_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_state_o,
    output logic [IDXW-1:0]  out_round_o,
    output logic             idx_err_o
);

    localparam logic [IDXW-1:0] MAX_IDX = IDXW'(ROUNDS);

    logic [WIDTH-1:0] key_q [0:ROUNDS];
    logic             idx_err_q;
    logic             rd_ok, wr_ok, accept;
    logic [WIDTH-1:0] key_sel, res;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_state_q, out_state_d;
    logic [IDXW-1:0]  out_round_q, out_round_d;

    assign rd_ok  = (in_round_i <= MAX_IDX);
    assign wr_ok  = (key_wr_idx_i <= MAX_IDX);
    assign accept = in_valid_i && in_ready_o;

    // Out-of-range round reads as an all-zero key so the state passes through.
    assign key_sel = rd_ok ? key_q[in_round_i] : '0;
    assign res     = in_state_i ^ key_sel;

    // Key store reads are combinational, so a same-cycle write is seen only next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= ROUNDS; i++) key_q[i] <= '0;
            idx_err_q <= 1'b0;
        end else begin
            if (key_wr_en_i && wr_ok) key_q[key_wr_idx_i] <= key_wr_data_i;
            if ((key_wr_en_i && !wr_ok) || (accept && !rd_ok)) idx_err_q <= 1'b1;
        end
    end

`ifdef ARK_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_state_q, skid_state_d;
    logic [IDXW-1:0]  skid_round_q, skid_round_d;

    // Only depends on registered skid occupancy; no path from out_ready_i.
    assign in_ready_o = !rst && !skid_valid_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_state_d  = out_state_q;
        out_round_d  = out_round_q;
        skid_valid_d = skid_valid_q;
        skid_state_d = skid_state_q;
        skid_round_d = skid_round_q;
        if (!out_valid_q || out_ready_i) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_state_d  = skid_state_q;
                out_round_d  = skid_round_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_state_d = res;
                out_round_d = in_round_i;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_state_d = res;
            skid_round_d = in_round_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_state_q <= '0;
            skid_round_q <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_state_q <= skid_state_d;
            skid_round_q <= skid_round_d;
        end
    end
`else
    assign in_ready_o = !rst && (!out_valid_q || out_ready_i);

    always_comb begin
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        out_round_d = out_round_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_state_d = res;
            out_round_d = in_round_i;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            out_round_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            out_round_q <= out_round_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_state_o = out_state_q;
    assign out_round_o = out_round_q;
    assign idx_err_o   = idx_err_q;

endmodule

// File: tb/tb_add_round_key_stream.sv
// Randomized bench for add_round_key_stream against a queue-based reference model.
module tb_add_round_key_stream;
    localparam int W  = 128;
    localparam int R  = 10;
    localparam int IW = 4;
`ifdef ARK_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          key_wr_en_i;
    logic [IW-1:0] key_wr_idx_i;
    logic [W-1:0]  key_wr_data_i;
    logic          in_valid_i, in_ready_o;
    logic [W-1:0]  in_state_i;
    logic [IW-1:0] in_round_i;
    logic          out_valid_o, out_ready_i;
    logic [W-1:0]  out_state_o;
    logic [IW-1:0] out_round_o;
    logic          idx_err_o;

    always #5 clk = ~clk;

    add_round_key_stream #(.WIDTH(W), .ROUNDS(R)) dut (
        .clk(clk), .rst(rst),
        .key_wr_en_i(key_wr_en_i), .key_wr_idx_i(key_wr_idx_i), .key_wr_data_i(key_wr_data_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_state_i(in_state_i), .in_round_i(in_round_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_state_o(out_state_o),
        .out_round_o(out_round_o), .idx_err_o(idx_err_o)
    );

    typedef struct packed { logic [W-1:0] s; logic [IW-1:0] r; } res_t;
    res_t         q[$];
    logic [W-1:0] mkey [0:R];
    bit           merr;
    int           n_chk = 0, n_pass = 0;

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // The block holds at most DEPTH results; without a skid a draining output frees the slot.
    function automatic bit exp_rdy();
        if (rst) return 1'b0;
        return (q.size() < DEPTH) || (DEPTH == 1 && out_ready_i);
    endfunction

    task automatic drv(input bit v, input logic [W-1:0] s, input logic [IW-1:0] r, input bit ordy,
                       input bit we, input logic [IW-1:0] wi, input logic [W-1:0] wd);
        in_valid_i = v; in_state_i = s; in_round_i = r; out_ready_i = ordy;
        key_wr_en_i = we; key_wr_idx_i = wi; key_wr_data_i = wd;
    endtask

    task automatic idle(input bit ordy);
        drv(0, '0, '0, ordy, 0, '0, '0);
    endtask

    // Advance one clock and update the model from the inputs present at that edge.
    task automatic tick();
        bit   acc, fire;
        res_t nr;
        int   ri;
        acc  = in_valid_i && exp_rdy();
        fire = (q.size() > 0) && out_ready_i;
        ri   = int'(in_round_i);
        nr.r = in_round_i;
        nr.s = (ri <= R) ? (in_state_i ^ mkey[ri]) : in_state_i;
        @(posedge clk);
        if (rst) begin
            q.delete(); merr = 0;
            for (int i = 0; i <= R; i++) mkey[i] = '0;
        end else begin
            if (fire) void'(q.pop_front());
            if (acc) begin
                q.push_back(nr);
                if (ri > R) merr = 1;
            end
            if (key_wr_en_i) begin
                if (int'(key_wr_idx_i) <= R) mkey[int'(key_wr_idx_i)] = key_wr_data_i;
                else merr = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] s;
        rst = 1'b1;
        drv(1, rnd(), 4'd0, 0, 1, 4'd0, rnd());
        @(negedge clk);
        n_chk++; if (in_ready_o !== 1'b0) $display("FAIL reset_rdy_low got=%b want=0", in_ready_o); else n_pass++;
        tick();
        tick();
        rst = 1'b0;
        idle(1);
        @(negedge clk);
        n_chk++; if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid_o); else n_pass++;
        n_chk++; if (out_state_o !== '0) $display("FAIL reset_out_state got=%h want=0", out_state_o); else n_pass++;
        n_chk++; if (out_round_o !== '0) $display("FAIL reset_out_round got=%0d want=0", out_round_o); else n_pass++;
        n_chk++; if (idx_err_o !== 1'b0) $display("FAIL reset_idx_err got=%b want=0", idx_err_o); else n_pass++;
        n_chk++; if (in_ready_o !== 1'b1) $display("FAIL reset_rdy_high got=%b want=1", in_ready_o); else n_pass++;
        // Key written during reset must not have landed.
        s = rnd();
        drv(1, s, 4'd0, 1, 0, '0, '0);
        tick();
        idle(1);
        @(negedge clk);
        n_chk++; if (out_valid_o !== 1'b1 || out_state_o !== s) $display("FAIL reset_key_zero got=%b/%h want=1/%h", out_valid_o, out_state_o, s); else n_pass++;
        tick();
    endtask

    task automatic test_vector();
        logic [W-1:0] k0, st, ex;
        k0 = 128'h000102030405060708090A0B0C0D0E0F;
        st = 128'h00112233445566778899AABBCCDDEEFF;
        ex = 128'h00102030405060708090A0B0C0D0E0F0;
        drv(0, '0, '0, 1, 1, 4'd0, k0);
        tick();
        drv(1, st, 4'd0, 1, 0, '0, '0);
        tick();
        idle(1);
        @(negedge clk);
        n_chk++; if (out_valid_o !== 1'b1) $display("FAIL vector_valid got=%b want=1", out_valid_o); else n_pass++;
        n_chk++; if (out_state_o !== ex) $display("FAIL vector_state got=%h want=%h", out_state_o, ex); else n_pass++;
        n_chk++; if (out_round_o !== 4'd0) $display("FAIL vector_round got=%0d want=0", out_round_o); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int nvalid = 0;
        for (int i = 0; i <= R; i++) begin
            drv(0, '0, '0, 1, 1, IW'(i), rnd());
            tick();
        end
        for (int c = 0; c < R + 3; c++) begin
            if (c <= R) drv(1, rnd(), IW'(c), 1, 0, '0, '0);
            else idle(1);
            @(negedge clk);
            if (c <= R) begin
                n_chk++; if (in_ready_o !== 1'b1) $display("FAIL b2b_rdy c=%0d got=%b want=1", c, in_ready_o); else n_pass++;
            end
            if (c >= 1 && c <= R + 1) begin
                n_chk++;
                if (out_valid_o !== 1'b1 || q.size() == 0 || out_state_o !== q[0].s || out_round_o !== q[0].r)
                    $display("FAIL b2b_out c=%0d got=%b/%h/%0d want=1/%h/%0d", c, out_valid_o, out_state_o, out_round_o, q[0].s, q[0].r);
                else n_pass++;
                if (out_valid_o === 1'b1) nvalid++;
            end
            tick();
        end
        n_chk++; if (nvalid !== R + 1) $display("FAIL b2b_count got=%0d want=%0d", nvalid, R + 1); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        int           nacc = 0;
        for (int c = 0; c < 5; c++) begin
            drv(1, rnd(), IW'($urandom_range(0, R)), 0, 0, '0, '0);
            @(negedge clk);
            n_chk++; if (in_ready_o !== (c < DEPTH)) $display("FAIL bp_rdy c=%0d got=%b want=%b", c, in_ready_o, c < DEPTH); else n_pass++;
            if (c == 1) held = out_state_o;
            if (c > 1) begin
                n_chk++; if (out_valid_o !== 1'b1 || out_state_o !== held) $display("FAIL bp_stable c=%0d got=%h want=%h", c, out_state_o, held); else n_pass++;
            end
            if (in_ready_o === 1'b1) nacc++;
            tick();
        end
        n_chk++; if (q.size() !== DEPTH || nacc !== DEPTH) $display("FAIL bp_accepts got=%0d want=%0d", nacc, DEPTH); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            idle(1);
            @(negedge clk);
            n_chk++;
            if (out_valid_o !== (q.size() > 0) || (q.size() > 0 && (out_state_o !== q[0].s || out_round_o !== q[0].r)))
                $display("FAIL bp_drain c=%0d got=%b/%h want=%0d-deep", c, out_valid_o, out_state_o, q.size());
            else n_pass++;
            tick();
        end
        n_chk++; if (q.size() != 0 || out_valid_o !== 1'b0) $display("FAIL bp_empty got=%b want=0", out_valid_o); else n_pass++;
    endtask

    task automatic test_same_cycle_write();
        logic [W-1:0] ka, kb, s1, s2;
        ka = rnd(); kb = rnd(); s1 = rnd(); s2 = rnd();
        drv(0, '0, '0, 1, 1, 4'd3, ka);
        tick();
        drv(1, s1, 4'd3, 1, 1, 4'd3, kb);
        tick();
        drv(1, s2, 4'd3, 1, 0, '0, '0);
        @(negedge clk);
        n_chk++; if (out_state_o !== (s1 ^ ka)) $display("FAIL samecyc_old got=%h want=%h", out_state_o, s1 ^ ka); else n_pass++;
        tick();
        idle(1);
        @(negedge clk);
        n_chk++; if (out_state_o !== (s2 ^ kb)) $display("FAIL samecyc_new got=%h want=%h", out_state_o, s2 ^ kb); else n_pass++;
        tick();
    endtask

    task automatic test_bad_index();
        logic [W-1:0] s;
        s = rnd();
        idle(1);
        @(negedge clk);
        n_chk++; if (idx_err_o !== 1'b0) $display("FAIL badidx_pre got=%b want=0", idx_err_o); else n_pass++;
        drv(1, s, 4'd12, 1, 0, '0, '0);
        tick();
        idle(1);
        @(negedge clk);
        n_chk++; if (out_valid_o !== 1'b1 || out_state_o !== s || out_round_o !== 4'd12) $display("FAIL badidx_out got=%b/%h/%0d want=1/%h/12", out_valid_o, out_state_o, out_round_o, s); else n_pass++;
        n_chk++; if (idx_err_o !== 1'b1) $display("FAIL badidx_err got=%b want=1", idx_err_o); else n_pass++;
        for (int c = 0; c < 4; c++) tick();
        n_chk++; if (idx_err_o !== 1'b1) $display("FAIL badidx_sticky got=%b want=1", idx_err_o); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        logic [W-1:0] s;
        drv(1, rnd(), 4'd1, 0, 0, '0, '0);
        tick();
        rst = 1'b1;
        drv(1, rnd(), 4'd2, 0, 1, 4'd3, rnd());
        @(negedge clk);
        n_chk++; if (in_ready_o !== 1'b0) $display("FAIL midrst_rdy_low got=%b want=0", in_ready_o); else n_pass++;
        tick();
        rst = 1'b0;
        idle(0);
        @(negedge clk);
        n_chk++; if (out_valid_o !== 1'b0 || out_state_o !== '0 || idx_err_o !== 1'b0)
            $display("FAIL midrst_clear got=%b/%h/%b want=0/0/0", out_valid_o, out_state_o, idx_err_o); else n_pass++;
        n_chk++; if (in_ready_o !== 1'b1) $display("FAIL midrst_rdy_high got=%b want=1", in_ready_o); else n_pass++;
        s = rnd();
        drv(1, s, 4'd3, 1, 0, '0, '0);
        tick();
        idle(1);
        @(negedge clk);
        n_chk++; if (out_state_o !== s) $display("FAIL midrst_keys got=%h want=%h", out_state_o, s); else n_pass++;
        tick();
    endtask

    task automatic test_bad_write();
        logic [W-1:0] s, k;
        s = rnd(); k = rnd();
        drv(0, '0, '0, 1, 1, 4'd7, k);
        tick();
        drv(0, '0, '0, 1, 1, 4'd13, rnd());
        tick();
        drv(1, s, 4'd7, 1, 0, '0, '0);
        tick();
        idle(1);
        @(negedge clk);
        n_chk++; if (idx_err_o !== 1'b1) $display("FAIL badwr_err got=%b want=1", idx_err_o); else n_pass++;
        n_chk++; if (out_state_o !== (s ^ k)) $display("FAIL badwr_keep got=%h want=%h", out_state_o, s ^ k); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drv($urandom_range(0, 3) != 0, rnd(), IW'(($urandom_range(0, 19) == 0) ? $urandom_range(11, 15) : $urandom_range(0, R)),
                $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
                IW'(($urandom_range(0, 29) == 0) ? $urandom_range(11, 15) : $urandom_range(0, R)), rnd());
            @(negedge clk);
            n_chk++; if (in_ready_o !== exp_rdy()) $display("FAIL rand_rdy c=%0d got=%b want=%b", c, in_ready_o, exp_rdy()); else n_pass++;
            n_chk++;
            if (out_valid_o !== (q.size() > 0) || (q.size() > 0 && (out_state_o !== q[0].s || out_round_o !== q[0].r)))
                $display("FAIL rand_out c=%0d got=%b/%h/%0d want=%0d-deep %h/%0d", c, out_valid_o, out_state_o, out_round_o, q.size(), q[0].s, q[0].r);
            else n_pass++;
            n_chk++; if (idx_err_o !== merr) $display("FAIL rand_err c=%0d got=%b want=%b", c, idx_err_o, merr); else n_pass++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle(1);
        test_reset();
        test_vector();
        test_back_to_back();
        test_backpressure();
        test_same_cycle_write();
        test_bad_index();
        test_reset_midflight();
        test_bad_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
